// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared constants for the execute stage.
//   - bit positions inside the one-hot mem_op / mul_op / div_op fields
//   - exception codes, including ECODE_ALE for misaligned accesses
//   - default reset PC
//   - is_misaligned(): alignment check for half/word loads and stores
package exe_stage_pkg;

  // mem_op bit positions
  localparam int MEM_LB  = 0;
  localparam int MEM_LBU = 1;
  localparam int MEM_LH  = 2;
  localparam int MEM_LHU = 3;
  localparam int MEM_LW  = 4;
  localparam int MEM_SB  = 5;
  localparam int MEM_SH  = 6;
  localparam int MEM_SW  = 7;

  // mul_op bit positions
  localparam int MUL_W    = 0;
  localparam int MULH_W   = 1;
  localparam int MULH_WU  = 2;

  // div_op bit positions
  localparam int DIV_W  = 0;
  localparam int DIV_WU = 1;
  localparam int MOD_W  = 2;
  localparam int MOD_WU = 3;

  // Exception codes
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

  // Half accesses need addr[0] clear, word accesses need addr[1:0] clear.
  // Byte accesses are always aligned.
  function automatic logic is_misaligned(input logic [7:0] mem_op,
                                         input logic [1:0] addr_lsb);
    logic half_acc;
    logic word_acc;
    half_acc = mem_op[MEM_LH] | mem_op[MEM_LHU] | mem_op[MEM_SH];
    word_acc = mem_op[MEM_LW] | mem_op[MEM_SW];
    return (half_acc && addr_lsb[0]) || (word_acc && (addr_lsb != 2'b00));
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: operand request bus from the execute stage to the external
// multiplier and divider.
//   master (execute stage): drives to_*_req_valid, *_src1, *_src2, *_signed
//                           and samples from_*_req_ready
//   slave  (mul/div units): the reverse
// A request transfers on any cycle where valid and ready are both high.
interface exe_stage_if;
  logic        to_mul_req_valid;
  logic        from_mul_req_ready;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic        mul_signed;

  logic        to_div_req_valid;
  logic        from_div_req_ready;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_signed;

  modport master (
    output to_mul_req_valid, mul_src1, mul_src2, mul_signed,
    output to_div_req_valid, div_src1, div_src2, div_signed,
    input  from_mul_req_ready, from_div_req_ready
  );

  modport slave (
    input  to_mul_req_valid, mul_src1, mul_src2, mul_signed,
    input  to_div_req_valid, div_src1, div_src2, div_signed,
    output from_mul_req_ready, from_div_req_ready
  );
endinterface

// File: rtl/exe_req_ctrl.sv
// exe_req_ctrl: one-shot request tracker for a multi-cycle unit (mul or div).
// Issues exactly one request per instruction held in the execute stage and
// remembers that it was accepted until the instruction leaves or is flushed.
//   clk, rst            clock, synchronous active-high reset
//   need_i              the instruction in stage needs this unit
//   req_ready_i         unit accepts the request this cycle
//   adv_i               the instruction leaves the stage this cycle
//   flush_i             pipeline flush
//   req_valid_o         request valid towards the unit
//   issued_or_firing_o  request already accepted, or being accepted now
module exe_req_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic need_i,
  input  logic req_ready_i,
  input  logic adv_i,
  input  logic flush_i,
  output logic req_valid_o,
  output logic issued_or_firing_o
);

  logic req_sent_q;
  logic req_sent_d;
  logic fire;

  // Gating with rst withdraws a pending request in the reset cycle itself.
  assign req_valid_o        = need_i && !req_sent_q && !rst;
  assign fire               = req_valid_o && req_ready_i;
  assign issued_or_firing_o = req_sent_q || fire;

  // A handshake coinciding with adv needs no memory: the instruction is gone.
  // NOTE: assign a default first in always_comb so no path leaves the
  // variable unassigned, which would infer a latch.
  always_comb begin
    req_sent_d = req_sent_q;
    if (adv_i || flush_i) begin
      req_sent_d = 1'b0;
    end else if (fire) begin
      req_sent_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sent_q <= 1'b0;
    end else begin
      req_sent_q <= req_sent_d;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage feeding the memory stage.
// Registers the ALU result and decode fields, requests the external
// multiplier/divider once per instruction, flags address-alignment
// exceptions (ALE) and provides a bypass path to decode.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        handshake with decode
//   out_valid/out_ready      handshake with memory
//   ex_flush, ertn_flush     flush from writeback
//   next_exception           exception pending further down the pipe
//   this_exception           this or a downstream stage is excepting
//   PC ... esubcode          decode-stage operands and flags
//   req_bus                  mul/div request bus (exe_stage_if.master)
//   fwd_*                    bypass to decode
//   *_out                    registered bundle for the memory stage
// Optional feature: define EXE_ALE_CHECK_EN to enable ALE detection; when
// undefined the exception fields pass through and exception_maddr_out = 0.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        ex_flush,
  input  logic        ertn_flush,
  input  logic        next_exception,
  output logic        this_exception,
  input  logic [31:0] PC,
  input  logic [31:0] alu_result,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] rkd_value,
  input  logic [7:0]  mem_op,
  input  logic [2:0]  mul_op,
  input  logic [3:0]  div_op,
  input  logic        res_from_mul,
  input  logic        res_from_div,
  input  logic        res_from_mem,
  input  logic        res_from_csr,
  input  logic        gr_we,
  input  logic        mem_we,
  input  logic        ertn,
  input  logic [4:0]  dest,
  input  logic        has_exception,
  input  logic [5:0]  ecode,
  input  logic [8:0]  esubcode,
  exe_stage_if.master req_bus,
  output logic        fwd_valid,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_value,
  output logic        fwd_stall,
  output logic [31:0] PC_out,
  output logic [31:0] result_out,
  output logic [31:0] rkd_value_out,
  output logic [7:0]  mem_op_out,
  output logic [2:0]  mul_op_out,
  output logic [3:0]  div_op_out,
  output logic        res_from_mul_out,
  output logic        res_from_div_out,
  output logic        res_from_mem_out,
  output logic        res_from_csr_out,
  output logic        gr_we_out,
  output logic        mem_we_out,
  output logic [4:0]  dest_out,
  output logic        has_exception_out,
  output logic [5:0]  ecode_out,
  output logic [8:0]  esubcode_out,
  output logic        ertn_out,
  output logic [31:0] exception_maddr_out
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] rkd_value;
    logic [7:0]  mem_op;
    logic [2:0]  mul_op;
    logic [3:0]  div_op;
    logic        res_from_mul;
    logic        res_from_div;
    logic        res_from_mem;
    logic        res_from_csr;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic        has_exception;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        ertn;
    logic [31:0] exception_maddr;
  } bundle_t;

  bundle_t bundle_q, bundle_d;
  logic    out_valid_q;
  logic    flush, ale, ready_go, adv;
  logic    mul_need, div_need, mul_done, div_done;

  assign flush = ex_flush || ertn_flush;

`ifdef EXE_ALE_CHECK_EN
  assign ale = is_misaligned(mem_op, alu_result[1:0]);
`else
  assign ale = 1'b0;
`endif

  assign this_exception = (in_valid && (has_exception || ale)) || next_exception;

  assign mul_need = in_valid && res_from_mul && !this_exception && !flush;
  assign div_need = in_valid && res_from_div && !this_exception && !flush;

  exe_req_ctrl u_mul_req (
    .clk                (clk),
    .rst                (rst),
    .need_i             (mul_need),
    .req_ready_i        (req_bus.from_mul_req_ready),
    .adv_i              (adv),
    .flush_i            (flush),
    .req_valid_o        (req_bus.to_mul_req_valid),
    .issued_or_firing_o (mul_done)
  );

  exe_req_ctrl u_div_req (
    .clk                (clk),
    .rst                (rst),
    .need_i             (div_need),
    .req_ready_i        (req_bus.from_div_req_ready),
    .adv_i              (adv),
    .flush_i            (flush),
    .req_valid_o        (req_bus.to_div_req_valid),
    .issued_or_firing_o (div_done)
  );

  assign req_bus.mul_src1   = src1;
  assign req_bus.mul_src2   = src2;
  assign req_bus.mul_signed = mul_op[MULH_W] | mul_op[MUL_W];
  assign req_bus.div_src1   = src1;
  assign req_bus.div_src2   = src2;
  assign req_bus.div_signed = div_op[DIV_W] | div_op[MOD_W];

  // Flushed or excepting instructions never wait on mul/div.
  assign ready_go = !in_valid || flush || this_exception ||
                    ((!res_from_mul || mul_done) && (!res_from_div || div_done));
  assign adv      = in_valid && ready_go && out_ready;
  assign in_ready = !rst && (!in_valid || (ready_go && out_ready));

  assign fwd_valid = in_valid && gr_we && (dest != 5'd0);
  assign fwd_dest  = dest;
  assign fwd_value = alu_result;
  assign fwd_stall = fwd_valid && (res_from_mem || res_from_mul || res_from_div || res_from_csr);

  always_comb begin
    bundle_d                 = bundle_q;
    bundle_d.pc              = PC;
    bundle_d.result          = alu_result;
    bundle_d.rkd_value       = rkd_value;
    bundle_d.mem_op          = mem_op;
    bundle_d.mul_op          = mul_op;
    bundle_d.div_op          = div_op;
    bundle_d.res_from_mul    = res_from_mul;
    bundle_d.res_from_div    = res_from_div;
    bundle_d.res_from_mem    = res_from_mem;
    bundle_d.res_from_csr    = res_from_csr;
    bundle_d.gr_we           = gr_we;
    bundle_d.mem_we          = mem_we;
    bundle_d.dest            = dest;
    bundle_d.ertn            = ertn;
    bundle_d.has_exception   = has_exception;
    bundle_d.ecode           = ecode;
    bundle_d.esubcode        = esubcode;
    bundle_d.exception_maddr = 32'd0;
    // An incoming exception is older than the ALE and keeps its codes.
    if (ale && !has_exception) begin
      bundle_d.has_exception   = 1'b1;
      bundle_d.ecode           = ECODE_ALE;
      bundle_d.esubcode        = 9'd0;
      bundle_d.exception_maddr = alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q    <= '0;
      bundle_q.pc <= RESET_PC;
      out_valid_q <= 1'b0;
    end else begin
      if (adv) begin
        bundle_q <= bundle_d;
      end
      if (out_ready) begin
        out_valid_q <= in_valid && ready_go && !flush;
      end
    end
  end

  assign out_valid           = out_valid_q;
  assign PC_out              = bundle_q.pc;
  assign result_out          = bundle_q.result;
  assign rkd_value_out       = bundle_q.rkd_value;
  assign mem_op_out          = bundle_q.mem_op;
  assign mul_op_out          = bundle_q.mul_op;
  assign div_op_out          = bundle_q.div_op;
  assign res_from_mul_out    = bundle_q.res_from_mul;
  assign res_from_div_out    = bundle_q.res_from_div;
  assign res_from_mem_out    = bundle_q.res_from_mem;
  assign res_from_csr_out    = bundle_q.res_from_csr;
  assign gr_we_out           = bundle_q.gr_we;
  assign mem_we_out          = bundle_q.mem_we;
  assign dest_out            = bundle_q.dest;
  assign has_exception_out   = bundle_q.has_exception;
  assign ecode_out           = bundle_q.ecode;
  assign esubcode_out        = bundle_q.esubcode;
  assign ertn_out            = bundle_q.ertn;
  assign exception_maddr_out = bundle_q.exception_maddr;

endmodule
